// File: rtl/memory_access_pkg.sv
// Shared constants and helpers for the RV32I memory stage.
// Holds the width constants, the load/store opcodes, the funct3 size codes,
// the FSM state type and the store-lane helper functions.
package memory_access_pkg;

  localparam int XLEN  = 32;
  localparam int XADDR = 5;
  localparam int OPLEN = 7;

  localparam logic [OPLEN-1:0] L_OP = 7'b0000011;
  localparam logic [OPLEN-1:0] S_OP = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  function automatic logic legal_load(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  function automatic logic legal_store(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
  endfunction

  // Byte enables for a store; a misaligned half falls back to the addr[1] lane.
  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      F3_B:    return 4'b0001 << a;
      F3_H:    return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Store data replicated across every lane the access could land in.
  function automatic logic [XLEN-1:0] store_wdata(input logic [2:0] f3,
                                                  input logic [XLEN-1:0] rs2);
    case (f3)
      F3_B:    return {4{rs2[7:0]}};
      F3_H:    return {2{rs2[15:0]}};
      default: return rs2;
    endcase
  endfunction

endpackage

// File: rtl/memory_access_load_align.sv
// load_align: selects the addressed byte/half from a read word and
// sign- or zero-extends it according to funct3. Purely combinational.
module load_align
  import memory_access_pkg::*;
(
  input  logic [XLEN-1:0] i_rdata,
  input  logic [1:0]      i_addr_lo,
  input  logic [2:0]      i_funct3,
  output logic [XLEN-1:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lane selection followed by extension
  always_comb begin
    case (i_addr_lo)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    case (i_funct3)
      F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
      F3_H:    o_data = {{16{w_half[15]}}, w_half};
      F3_BU:   o_data = {24'd0, w_byte};
      F3_HU:   o_data = {16'd0, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/memory_access.sv
// memory_access: RV32I memory stage. Captures execute's slot, runs load/store
// accesses on a req/ack port, aligns load data and registers the result toward
// writeback (the rd outputs double as the forwarding source).
// Optional build macro MISALIGN_TRAP_EN: misaligned half/word accesses make no
// request and instead pulse or_misalign with the faulting address in or_rd_data.
module memory_access
  import memory_access_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [OPLEN-1:0] i_opcode,
  input  logic [2:0]       i_funct3,
  input  logic [XLEN-1:0]  i_rs2_data,
  input  logic [XADDR-1:0] i_rd_addr,
  input  logic             i_rd_wr_en,
  input  logic [XLEN-1:0]  i_alu_result,
  input  logic [XLEN-1:0]  i_pc,
  input  logic             i_flush,
  output logic             o_dmem_req,
  output logic             o_dmem_we,
  output logic [XLEN-1:0]  o_dmem_addr,
  output logic [XLEN-1:0]  o_dmem_wdata,
  output logic [3:0]       o_dmem_be,
  input  logic             i_dmem_ack,
  input  logic [XLEN-1:0]  i_dmem_rdata,
  output logic [OPLEN-1:0] or_opcode,
  output logic [XADDR-1:0] or_rd_addr,
  output logic             or_rd_wr_en,
  output logic [XLEN-1:0]  or_rd_data,
  output logic [XLEN-1:0]  or_pc,
  output logic             or_stall,
  output logic             or_misalign
);

  state_t r_state;
  state_t w_next_state;

  logic w_is_load;
  logic w_is_store;
  logic w_legal;
  logic w_misalign;
  logic w_start;

  // Access context latched at capture; only meaningful while BUSY
  logic [XLEN-1:0]  r_addr;
  logic [2:0]       r_funct3;
  logic [XLEN-1:0]  r_rs2;
  logic [XADDR-1:0] r_rd_addr;
  logic             r_rd_wr_en;
  logic [XLEN-1:0]  r_pc;
  logic [OPLEN-1:0] r_opcode;
  logic             r_store;

  logic [XLEN-1:0]  w_load_data;

  load_align u_load_align (
    .i_rdata   (i_dmem_rdata),
    .i_addr_lo (r_addr[1:0]),
    .i_funct3  (r_funct3),
    .o_data    (w_load_data)
  );

  // Decode the incoming slot: legal access, misalignment, and whether to start
  always_comb begin
    w_is_load  = (i_opcode == L_OP);
    w_is_store = (i_opcode == S_OP);
    w_legal    = (w_is_load && legal_load(i_funct3)) ||
                 (w_is_store && legal_store(i_funct3));
`ifdef MISALIGN_TRAP_EN
    w_misalign = !i_flush && w_legal &&
                 (((i_funct3[1:0] == 2'b01) && i_alu_result[0]) ||
                  ((i_funct3[1:0] == 2'b10) && (i_alu_result[1:0] != 2'b00)));
`else
    w_misalign = 1'b0;
`endif
    w_start    = !i_flush && w_legal && !w_misalign;
  end

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state logic: an accepted access is held until ack, never aborted
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_start)    w_next_state = S_BUSY;
      S_BUSY:  if (i_dmem_ack) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Memory port outputs, stable for the whole BUSY span and zero otherwise
  always_comb begin
    o_dmem_req   = 1'b0;
    o_dmem_we    = 1'b0;
    o_dmem_addr  = '0;
    o_dmem_wdata = '0;
    o_dmem_be    = 4'b0000;
    if (r_state == S_BUSY) begin
      o_dmem_req  = 1'b1;
      o_dmem_we   = r_store;
      o_dmem_addr = {r_addr[XLEN-1:2], 2'b00};
      if (r_store) begin
        o_dmem_be    = store_be(r_funct3, r_addr[1:0]);
        o_dmem_wdata = store_wdata(r_funct3, r_rs2);
      end else begin
        o_dmem_be    = 4'b1111;
      end
    end
  end

  // Latch the access context when an access is accepted
  always_ff @(posedge i_clk) begin
    if (r_state == S_IDLE && w_start) begin
      r_addr     <= i_alu_result;
      r_funct3   <= i_funct3;
      r_rs2      <= i_rs2_data;
      r_rd_addr  <= i_rd_addr;
      r_rd_wr_en <= i_rd_wr_en;
      r_pc       <= i_pc;
      r_opcode   <= i_opcode;
      r_store    <= w_is_store;
    end
  end

  // Registered writeback/forwarding outputs and the upstream stall
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      or_opcode   <= '0;
      or_rd_addr  <= '0;
      or_rd_wr_en <= 1'b0;
      or_rd_data  <= '0;
      or_pc       <= '0;
      or_stall    <= 1'b0;
      or_misalign <= 1'b0;
    end else if (r_state == S_IDLE) begin
      or_opcode   <= i_opcode;
      or_rd_addr  <= i_rd_addr;
      or_rd_data  <= i_alu_result;
      or_pc       <= i_pc;
      // Any memory opcode (legal, illegal or trapped) leaves a bubble here
      or_rd_wr_en <= i_rd_wr_en && !i_flush && !w_is_load && !w_is_store;
      or_stall    <= w_start;
      or_misalign <= w_misalign;
    end else if (i_dmem_ack) begin
      or_opcode   <= r_opcode;
      or_rd_addr  <= r_rd_addr;
      or_pc       <= r_pc;
      or_rd_data  <= r_store ? r_addr : w_load_data;
      or_rd_wr_en <= r_rd_wr_en && !r_store;
      or_stall    <= 1'b0;
      or_misalign <= 1'b0;
    end
  end

endmodule

// File: tb/tb_memory_access.sv
// Bench for memory_access: vector table for single-cycle slots, hand-written
// multi-cycle sequences, and a randomized load/store run against a byte-level
// memory model.
module tb_memory_access;
  import memory_access_pkg::*;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [6:0]       opcode = '0;
  logic [2:0]       funct3 = '0;
  logic [31:0]      rs2 = '0;
  logic [4:0]       rd = '0;
  logic             rd_we = 1'b0;
  logic [31:0]      alu = '0;
  logic [31:0]      pc = '0;
  logic             flush = 1'b0;
  logic             req, we;
  logic [31:0]      maddr, wdata;
  logic [3:0]       be;
  logic             ack = 1'b0;
  logic [31:0]      rdata = '0;
  logic [6:0]       q_op;
  logic [4:0]       q_rd;
  logic             q_we;
  logic [31:0]      q_data, q_pc;
  logic             q_stall, q_mis;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [6:0] R_OP = 7'b0110011;
  localparam logic [6:0] I_OP = 7'b0010011;

  logic [7:0]  mem8 [0:63];
  logic [31:0] dev_mem [0:15];

  memory_access dut (
    .i_clk(clk), .i_rst(rst), .i_opcode(opcode), .i_funct3(funct3),
    .i_rs2_data(rs2), .i_rd_addr(rd), .i_rd_wr_en(rd_we), .i_alu_result(alu),
    .i_pc(pc), .i_flush(flush), .o_dmem_req(req), .o_dmem_we(we),
    .o_dmem_addr(maddr), .o_dmem_wdata(wdata), .o_dmem_be(be),
    .i_dmem_ack(ack), .i_dmem_rdata(rdata), .or_opcode(q_op),
    .or_rd_addr(q_rd), .or_rd_wr_en(q_we), .or_rd_data(q_data), .or_pc(q_pc),
    .or_stall(q_stall), .or_misalign(q_mis)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d2, input logic [4:0] r, input logic w,
                       input logic fl, input logic [31:0] p);
    opcode = op; funct3 = f3; alu = a; rs2 = d2; rd = r; rd_we = w; flush = fl; pc = p;
  endtask

  // One load/store from capture to ack, with wt wait cycles before the ack.
  task automatic mem_op(input string nm, input bit st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d2, input logic [4:0] r,
                        input int wt, input logic [31:0] rdw, input logic [31:0] e_addr,
                        input logic [3:0] e_be, input logic [31:0] e_wdata,
                        input logic [31:0] e_data);
    logic [31:0] p;
    p = $urandom & 32'hFFFF_FFFC;
    drive(st ? S_OP : L_OP, f3, a, d2, r, 1'b1, 1'b0, p);
    tick();
    check({nm, " req@E0"}, {31'd0, req}, 32'd1);
    check({nm, " stall@E0"}, {31'd0, q_stall}, 32'd1);
    check({nm, " bubble@E0"}, {31'd0, q_we}, 32'd0);
    check({nm, " we"}, {31'd0, we}, {31'd0, st});
    check({nm, " addr"}, maddr, e_addr);
    check({nm, " be"}, {28'd0, be}, {28'd0, e_be});
    if (st) check({nm, " wdata"}, wdata, e_wdata);
    // Upstream noise during BUSY must be ignored
    drive(R_OP, 3'd0, $urandom, $urandom, 5'($urandom), 1'b1, 1'($urandom), $urandom);
    for (int i = 0; i < wt; i++) begin
      tick();
      check({nm, " req held"}, {31'd0, req}, 32'd1);
      check({nm, " stall held"}, {31'd0, q_stall}, 32'd1);
      check({nm, " addr held"}, maddr, e_addr);
      check({nm, " wr_en busy"}, {31'd0, q_we}, 32'd0);
    end
    ack = 1'b1;
    rdata = st ? 32'h0 : rdw;
    if (st) begin
      for (int l = 0; l < 4; l++)
        if (be[l]) dev_mem[maddr[5:2]][8*l +: 8] = wdata[8*l +: 8];
    end
    tick();
    ack = 1'b0;
    rdata = 32'h0;
    check({nm, " req done"}, {31'd0, req}, 32'd0);
    check({nm, " stall done"}, {31'd0, q_stall}, 32'd0);
    check({nm, " wr_en done"}, {31'd0, q_we}, st ? 32'd0 : 32'd1);
    check({nm, " opcode"}, {25'd0, q_op}, {25'd0, st ? S_OP : L_OP});
    check({nm, " pc"}, q_pc, p);
    check({nm, " misalign"}, {31'd0, q_mis}, 32'd0);
    if (!st) begin
      check({nm, " rd_data"}, q_data, e_data);
      check({nm, " rd_addr"}, {27'd0, q_rd}, {27'd0, r});
    end
  endtask

  function automatic int size_of(input logic [2:0] f3);
    return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input int ea);
    int sz;
    logic [31:0] v;
    sz = size_of(f3);
    v = 0;
    for (int k = 0; k < sz; k++) v = v | (32'(mem8[ea + k]) << (8 * k));
    if (!f3[2] && sz < 4 && v[8*sz-1]) v = v - (32'd1 << (8 * sz));
    return v;
  endfunction

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [4:0]  r;
    logic        w;
    logic        fl;
    logic        exp_we;
  } vec_t;

  vec_t vecs [0:8];

  initial begin
    vecs[0] = '{R_OP,  3'd0, 32'h0000_1234, 5'd5,  1'b1, 1'b0, 1'b1};
    vecs[1] = '{I_OP,  3'd0, 32'hDEAD_BEEF, 5'd31, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{R_OP,  3'd0, 32'h5555_AAAA, 5'd7,  1'b0, 1'b0, 1'b0};
    vecs[3] = '{R_OP,  3'd0, 32'h0BAD_F00D, 5'd9,  1'b1, 1'b1, 1'b0};
    vecs[4] = '{L_OP,  3'd3, 32'h0000_0010, 5'd1,  1'b1, 1'b0, 1'b0};
    vecs[5] = '{L_OP,  3'd6, 32'h0000_0014, 5'd2,  1'b1, 1'b0, 1'b0};
    vecs[6] = '{S_OP,  3'd4, 32'h0000_0018, 5'd3,  1'b1, 1'b0, 1'b0};
    vecs[7] = '{L_OP,  3'd2, 32'h0000_001C, 5'd4,  1'b1, 1'b1, 1'b0};
    vecs[8] = '{S_OP,  3'd7, 32'h0000_0020, 5'd6,  1'b1, 1'b0, 1'b0};

    for (int i = 0; i < 16; i++) begin
      dev_mem[i] = $urandom;
      for (int k = 0; k < 4; k++) mem8[4*i + k] = dev_mem[i][8*k +: 8];
    end

    // Reset state
    repeat (2) tick();
    check("reset req", {31'd0, req}, 32'd0);
    check("reset stall", {31'd0, q_stall}, 32'd0);
    check("reset wr_en", {31'd0, q_we}, 32'd0);
    check("reset rd_data", q_data, 32'd0);
    check("reset pc", q_pc, 32'd0);
    check("reset misalign", {31'd0, q_mis}, 32'd0);
    rst = 1'b0;
    tick();

    // Single-cycle slots from the table
    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].op, vecs[i].f3, vecs[i].a, 32'h1111_2222, vecs[i].r, vecs[i].w,
            vecs[i].fl, 32'h100 + 32'(4 * i));
      tick();
      check($sformatf("vec%0d wr_en", i), {31'd0, q_we}, {31'd0, vecs[i].exp_we});
      check($sformatf("vec%0d req", i), {31'd0, req}, 32'd0);
      check($sformatf("vec%0d stall", i), {31'd0, q_stall}, 32'd0);
      check($sformatf("vec%0d opcode", i), {25'd0, q_op}, {25'd0, vecs[i].op});
      if (vecs[i].exp_we) begin
        check($sformatf("vec%0d rd_data", i), q_data, vecs[i].a);
        check($sformatf("vec%0d rd_addr", i), {27'd0, q_rd}, {27'd0, vecs[i].r});
        check($sformatf("vec%0d pc", i), q_pc, 32'h100 + 32'(4 * i));
      end
    end

    // Hand-written multi-cycle cases
    mem_op("LB 0x103", 1'b0, F3_B, 32'h103, 32'h0, 5'd10, 2, 32'h80FF_0000,
           32'h100, 4'b1111, 32'h0, 32'hFFFF_FF80);
    mem_op("SH 0x202", 1'b1, F3_H, 32'h202, 32'hABCD_1234, 5'd11, 0, 32'h0,
           32'h200, 4'b1100, 32'h1234_1234, 32'h0);
    mem_op("LHU 0x2", 1'b0, F3_HU, 32'h2, 32'h0, 5'd12, 0, 32'h8001_0000,
           32'h0, 4'b1111, 32'h0, 32'h0000_8001);
    mem_op("SB 0x41", 1'b1, F3_B, 32'h41, 32'h0000_00A5, 5'd0, 1, 32'h0,
           32'h40, 4'b0010, 32'hA5A5_A5A5, 32'h0);

    // Reset in the middle of an access, then a stray ack in IDLE
    drive(L_OP, F3_W, 32'h30, 32'h0, 5'd3, 1'b1, 1'b0, 32'h44);
    tick();
    check("rst-mid req before", {31'd0, req}, 32'd1);
    drive(7'd0, 3'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 32'd0);
    rst = 1'b1;
    #1;
    check("rst-mid req drop", {31'd0, req}, 32'd0);
    check("rst-mid stall drop", {31'd0, q_stall}, 32'd0);
    tick();
    rst = 1'b0;
    ack = 1'b1;
    rdata = 32'hFFFF_FFFF;
    tick();
    ack = 1'b0;
    rdata = 32'h0;
    tick();
    check("rst-mid req after ack", {31'd0, req}, 32'd0);
    check("rst-mid stall after ack", {31'd0, q_stall}, 32'd0);
    check("rst-mid wr_en", {31'd0, q_we}, 32'd0);
    check("rst-mid rd_data", q_data, 32'd0);
    check("rst-mid opcode", {25'd0, q_op}, 32'd0);

    // Misaligned accesses
`ifdef MISALIGN_TRAP_EN
    drive(L_OP, F3_W, 32'h6, 32'h0, 5'd8, 1'b1, 1'b0, 32'h500);
    tick();
    check("trap LW req", {31'd0, req}, 32'd0);
    check("trap LW misalign", {31'd0, q_mis}, 32'd1);
    check("trap LW rd_data", q_data, 32'h6);
    check("trap LW pc", q_pc, 32'h500);
    check("trap LW wr_en", {31'd0, q_we}, 32'd0);
    check("trap LW stall", {31'd0, q_stall}, 32'd0);
    drive(S_OP, F3_H, 32'h3, 32'h0, 5'd0, 1'b1, 1'b0, 32'h504);
    tick();
    check("trap SH req", {31'd0, req}, 32'd0);
    check("trap SH misalign", {31'd0, q_mis}, 32'd1);
    drive(R_OP, 3'd0, 32'h77, 32'h0, 5'd1, 1'b1, 1'b0, 32'h508);
    tick();
    check("trap pulse end", {31'd0, q_mis}, 32'd0);
`else
    mem_op("LW 0x6", 1'b0, F3_W, 32'h6, 32'h0, 5'd8, 1, 32'h1122_3344,
           32'h4, 4'b1111, 32'h0, 32'h1122_3344);
    mem_op("SH 0x3", 1'b1, F3_H, 32'h3, 32'h0000_BEEF, 5'd0, 0, 32'h0,
           32'h0, 4'b1100, 32'hBEEF_BEEF, 32'h0);
    dev_mem[0] = 32'h0;
    for (int k = 0; k < 4; k++) mem8[k] = 8'h0;
`endif

    // Randomized run against the byte-level model
    for (int n = 0; n < 60; n++) begin
      int kind;
      kind = $urandom_range(0, 2);
      if (kind == 0) begin
        logic [31:0] a;
        logic [4:0]  r;
        logic        w, fl;
        a = $urandom; r = 5'($urandom); w = 1'($urandom); fl = 1'($urandom);
        drive(I_OP, 3'd0, a, 32'h0, r, w, fl, 32'h900);
        tick();
        check("rnd alu wr_en", {31'd0, q_we}, {31'd0, w & ~fl});
        check("rnd alu req", {31'd0, req}, 32'd0);
        if (w & ~fl) check("rnd alu rd_data", q_data, a);
      end else begin
        logic [2:0]  f3;
        logic [31:0] a, d2, ewd;
        logic [3:0]  ebe;
        int          sz, ea;
        bit          st;
        st = (kind == 2);
        if (st) f3 = 3'($urandom_range(0, 2));
        else begin
          case ($urandom_range(0, 4))
            0: f3 = F3_B; 1: f3 = F3_H; 2: f3 = F3_W; 3: f3 = F3_BU; default: f3 = F3_HU;
          endcase
        end
        sz = size_of(f3);
        ea = $urandom_range(0, 63) & ~(sz - 1);
        a = 32'(ea);
        d2 = $urandom;
        ebe = 4'b0000;
        for (int k = 0; k < sz; k++) ebe[(ea % 4) + k] = 1'b1;
        ewd = (sz == 1) ? {4{d2[7:0]}} : (sz == 2) ? {2{d2[15:0]}} : d2;
        if (st) begin
          for (int k = 0; k < sz; k++) mem8[ea + k] = d2[8*k +: 8];
          mem_op("rnd store", 1'b1, f3, a, d2, 5'($urandom), $urandom_range(0, 3),
                 32'h0, a & 32'hFFFF_FFFC, ebe, ewd, 32'h0);
        end else begin
          mem_op("rnd load", 1'b0, f3, a, 32'h0, 5'($urandom), $urandom_range(0, 3),
                 dev_mem[ea / 4], a & 32'hFFFF_FFFC, 4'b1111, 32'h0,
                 model_load(f3, ea));
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
